jelly3_axi4l_cmd_master: RTL and testbench

- Converts a simple valid/ready command stream into single AXI4-Lite write or read transactions on a master interface.
- Returns each completed transaction's response on a valid/ready response stream.
- Sits directly upstream of AXI4-Lite register slaves; used by sequencers and debug bridges to program register banks.
- Exactly one transaction is outstanding at a time.

---
 rtl/jelly3_axi4l_if.sv | 47 ++++
 rtl/jelly3_axi4l_cmd_master.sv | 148 ++++++++++++++
 tb/tb_jelly3_axi4l_cmd_master.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jelly3_axi4l_if.sv
// jelly3_axi4l_if: AXI4-Lite bus bundle with master and slave views.
interface jelly3_axi4l_if #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int STRB_BITS = DATA_BITS / 8
) (
    input logic aresetn,
    input logic aclk
);
    logic [ADDR_BITS-1:0] awaddr;
    logic [2:0]           awprot;
    logic                 awvalid;
    logic                 awready;
    logic [DATA_BITS-1:0] wdata;
    logic [STRB_BITS-1:0] wstrb;
    logic                 wvalid;
    logic                 wready;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;
    logic [ADDR_BITS-1:0] araddr;
    logic [2:0]           arprot;
    logic                 arvalid;
    logic                 arready;
    logic [DATA_BITS-1:0] rdata;
    logic [1:0]           rresp;
    logic                 rvalid;
    logic                 rready;

    modport m (
        input  aresetn, aclk,
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport s (
        input  aresetn, aclk,
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/jelly3_axi4l_cmd_master.sv
// jelly3_axi4l_cmd_master: turns a valid/ready command stream into single AXI4-Lite transactions.
module jelly3_axi4l_cmd_master #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int STRB_BITS = DATA_BITS / 8
) (
    input  logic                 aresetn,
    input  logic                 aclk,
    input  logic                 cmd_write,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [DATA_BITS-1:0] cmd_wdata,
    input  logic [STRB_BITS-1:0] cmd_wstrb,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    output logic                 rsp_write,
    output logic [DATA_BITS-1:0] rsp_rdata,
    output logic [1:0]           rsp_resp,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    jelly3_axi4l_if.m            m_axi4l
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WRITE  = 3'd1;
    localparam logic [2:0] WAIT_B = 3'd2;
    localparam logic [2:0] READ   = 3'd3;
    localparam logic [2:0] WAIT_R = 3'd4;
    localparam logic [2:0] RESP   = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [STRB_BITS-1:0] wstrb_q, wstrb_d;
    logic                 awvalid_q, awvalid_d;
    logic                 wvalid_q, wvalid_d;
    logic                 arvalid_q, arvalid_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_write_q, rsp_write_d;
    logic [DATA_BITS-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]           rsp_resp_q, rsp_resp_d;
    logic                 aw_done, w_done, bready, rready;

    // a channel counts as done once its valid has dropped or its handshake is happening now
    assign aw_done   = !awvalid_q || m_axi4l.awready;
    assign w_done    = !wvalid_q || m_axi4l.wready;
    assign bready    = (state_q == WAIT_B) || (state_q == WRITE && aw_done && w_done);
    assign rready    = (state_q == WAIT_R) || (state_q == READ);
    assign cmd_ready = (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                addr_d    = cmd_addr;
                wdata_d   = cmd_wdata;
                wstrb_d   = cmd_wstrb;
                awvalid_d = cmd_write;
                wvalid_d  = cmd_write;
                arvalid_d = !cmd_write;
                state_d   = cmd_write ? WRITE : READ;
            end
            WRITE: begin
                awvalid_d = awvalid_q && !m_axi4l.awready;
                wvalid_d  = wvalid_q && !m_axi4l.wready;
                state_d   = (aw_done && w_done) ? WAIT_B : WRITE;
            end
            READ: begin
                arvalid_d = arvalid_q && !m_axi4l.arready;
                state_d   = m_axi4l.arready ? WAIT_R : READ;
            end
            RESP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            WAIT_B, WAIT_R: ;
            default: state_d = IDLE;
        endcase
        if (bready && m_axi4l.bvalid) begin
            rsp_resp_d  = m_axi4l.bresp;
            rsp_write_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
        end
        if (rready && m_axi4l.rvalid) begin
            rsp_rdata_d = m_axi4l.rdata;
            rsp_resp_d  = m_axi4l.rresp;
            rsp_write_d = 1'b0;
            rsp_valid_d = 1'b1;
            arvalid_d   = 1'b0;
            state_d     = RESP;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

    assign m_axi4l.awaddr  = addr_q;
    assign m_axi4l.awprot  = 3'b000;
    assign m_axi4l.awvalid = awvalid_q;
    assign m_axi4l.wdata   = wdata_q;
    assign m_axi4l.wstrb   = wstrb_q;
    assign m_axi4l.wvalid  = wvalid_q;
    assign m_axi4l.bready  = bready;
    assign m_axi4l.araddr  = addr_q;
    assign m_axi4l.arprot  = 3'b000;
    assign m_axi4l.arvalid = arvalid_q;
    assign m_axi4l.rready  = rready;
endmodule

// File: tb/tb_jelly3_axi4l_cmd_master.sv
// tb_jelly3_axi4l_cmd_master: directed bench with a behavioural AXI4-Lite register slave.
module tb_jelly3_axi4l_cmd_master;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 aclk = ~aclk;

    jelly3_axi4l_if #(.ADDR_BITS(32), .DATA_BITS(32)) axi (.aresetn(aresetn), .aclk(aclk));

    jelly3_axi4l_cmd_master #(.ADDR_BITS(32), .DATA_BITS(32)) dut (
        .aresetn(aresetn), .aclk(aclk),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .m_axi4l(axi)
    );

    // slave: ready after a programmable number of valid cycles, B one cycle after both AW and W
    int          aw_delay = 0;
    int          w_delay = 0;
    bit          r_err = 1'b0;
    bit          b_hold = 1'b0;
    int          aw_cnt, w_cnt;
    int          b_count = 0;
    int          rsp_count = 0;
    logic        aw_got, w_got, b_pend, rvalid_s;
    logic        aw_hs, w_hs, ar_hs;
    logic [31:0] aw_a, w_d, wr_d, rdata_s;
    logic [3:0]  w_s, wr_s, wr_idx;
    logic [1:0]  rresp_s;
    logic [31:0] mem [16];

    assign aw_hs       = axi.awvalid && axi.awready;
    assign w_hs        = axi.wvalid && axi.wready;
    assign ar_hs       = axi.arvalid && axi.arready;
    assign axi.awready = axi.awvalid && (aw_cnt >= aw_delay);
    assign axi.wready  = axi.wvalid && (w_cnt >= w_delay);
    assign axi.bvalid  = b_pend && !b_hold;
    assign axi.bresp   = 2'b00;
    assign axi.arready = axi.arvalid;
    assign axi.rvalid  = rvalid_s;
    assign axi.rdata   = rdata_s;
    assign axi.rresp   = rresp_s;
    assign wr_idx      = aw_got ? aw_a[5:2] : axi.awaddr[5:2];
    assign wr_d        = w_got ? w_d : axi.wdata;
    assign wr_s        = w_got ? w_s : axi.wstrb;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_cnt   <= 0;
            w_cnt    <= 0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            b_pend   <= 1'b0;
            rvalid_s <= 1'b0;
            aw_a     <= '0;
            w_d      <= '0;
            w_s      <= '0;
            rdata_s  <= '0;
            rresp_s  <= '0;
        end else begin
            aw_cnt <= aw_hs ? 0 : (axi.awvalid ? aw_cnt + 1 : aw_cnt);
            w_cnt  <= w_hs ? 0 : (axi.wvalid ? w_cnt + 1 : w_cnt);
            if (aw_hs) begin
                aw_got <= 1'b1;
                aw_a   <= axi.awaddr;
            end
            if (w_hs) begin
                w_got <= 1'b1;
                w_d   <= axi.wdata;
                w_s   <= axi.wstrb;
            end
            if ((aw_got || aw_hs) && (w_got || w_hs) && !b_pend) begin
                for (int i = 0; i < 4; i++)
                    if (wr_s[i]) mem[wr_idx][8*i +: 8] <= wr_d[8*i +: 8];
                b_pend <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (axi.bvalid && axi.bready) b_pend <= 1'b0;
            if (ar_hs) begin
                rvalid_s <= 1'b1;
                rdata_s  <= r_err ? 32'hDEAD_BEEF : mem[axi.araddr[5:2]];
                rresp_s  <= r_err ? 2'b10 : 2'b00;
            end else if (axi.rvalid && axi.rready) begin
                rvalid_s <= 1'b0;
            end
        end
    end

    always @(posedge aclk) begin
        if (axi.bvalid && axi.bready) b_count <= b_count + 1;
        if (rsp_valid && rsp_ready) rsp_count <= rsp_count + 1;
    end

    // stimulus helpers: all drive inputs at 1 time unit after a rising edge
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int i = 0; i < 20 && !cmd_ready; i++) begin
            @(posedge aclk); #1;
        end
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (rsp_valid) ok = 1'b1;
            else begin
                @(posedge aclk); #1;
            end
        end
    endtask

    task automatic take_rsp;
        rsp_ready = 1'b1;
        @(posedge aclk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_cmp++;
        if ({cmd_ready, axi.awvalid, axi.wvalid, axi.arvalid, rsp_valid, rsp_write} !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 100000", {cmd_ready, axi.awvalid, axi.wvalid, axi.arvalid, rsp_valid, rsp_write});
        end
        n_cmp++;
        if ({rsp_rdata, rsp_resp, axi.awaddr, axi.wdata, axi.wstrb} !== 102'd0) begin
            n_err++;
            $display("FAIL reset_data: rdata %h resp %b awaddr %h wdata %h wstrb %b expected all zero", rsp_rdata, rsp_resp, axi.awaddr, axi.wdata, axi.wstrb);
        end
        #20 aresetn = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic test_write_latency;
        send(1'b1, 32'h4, 32'hA5A5_1234, 4'hF);
        n_cmp++;
        if ({axi.awvalid, axi.wvalid, cmd_ready, rsp_valid, axi.awaddr, axi.wdata} !== {4'b1100, 32'h4, 32'hA5A5_1234}) begin
            n_err++;
            $display("FAIL wr_cycle1: awv %b wv %b crdy %b rv %b awaddr %h wdata %h expected 1 1 0 0 4 a5a51234", axi.awvalid, axi.wvalid, cmd_ready, rsp_valid, axi.awaddr, axi.wdata);
        end
        @(posedge aclk); #1;
        n_cmp++;
        if ({axi.bvalid, axi.bready, rsp_valid} !== 3'b110) begin
            n_err++;
            $display("FAIL wr_cycle2: bvalid/bready/rsp_valid got %b expected 110", {axi.bvalid, axi.bready, rsp_valid});
        end
        @(posedge aclk); #1;
        n_cmp++;
        if ({rsp_valid, rsp_write, rsp_resp, rsp_rdata} !== {2'b11, 2'b00, 32'h0}) begin
            n_err++;
            $display("FAIL wr_cycle3: valid %b write %b resp %b rdata %h expected 1 1 00 0", rsp_valid, rsp_write, rsp_resp, rsp_rdata);
        end
        take_rsp();
        n_cmp++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL wr_release: cmd_ready/rsp_valid got %b expected 10", {cmd_ready, rsp_valid});
        end
    endtask

    task automatic test_read;
        bit ok;
        send(1'b0, 32'h4, 32'h0, 4'h0);
        wait_rsp(ok);
        n_cmp++;
        if (!ok || {rsp_write, rsp_resp, rsp_rdata} !== {3'b000, 32'hA5A5_1234}) begin
            n_err++;
            $display("FAIL rd_back: ok %b write %b resp %b rdata %h expected 1 0 00 a5a51234", ok, rsp_write, rsp_resp, rsp_rdata);
        end
        take_rsp();
    endtask

    task automatic test_partial_strobe;
        bit ok;
        send(1'b1, 32'h8, 32'hFFFF_FFFF, 4'hF);
        wait_rsp(ok);
        take_rsp();
        send(1'b1, 32'h8, 32'h0000_0000, 4'b0101);
        wait_rsp(ok);
        take_rsp();
        send(1'b0, 32'h8, 32'h0, 4'h0);
        wait_rsp(ok);
        n_cmp++;
        if (!ok || rsp_rdata !== 32'hFF00_FF00) begin
            n_err++;
            $display("FAIL partial_strobe: ok %b rdata %h expected ff00ff00", ok, rsp_rdata);
        end
        take_rsp();
    endtask

    task automatic test_skewed;
        bit ok;
        int b0, r0;
        b0 = b_count;
        r0 = rsp_count;
        aw_delay = 3;
        send(1'b1, 32'hC, 32'h1357_9BDF, 4'hF);
        n_cmp++;
        if ({axi.awvalid, axi.awready, axi.wvalid, axi.wready} !== 4'b1011) begin
            n_err++;
            $display("FAIL skew_c1: awv/awr/wv/wr got %b expected 1011", {axi.awvalid, axi.awready, axi.wvalid, axi.wready});
        end
        for (int k = 2; k <= 4; k++) begin
            @(posedge aclk); #1;
            n_cmp++;
            if ({axi.awvalid, axi.wvalid, axi.awaddr} !== {2'b10, 32'hC}) begin
                n_err++;
                $display("FAIL skew_hold c%0d: awv %b wv %b awaddr %h expected 1 0 c", k, axi.awvalid, axi.wvalid, axi.awaddr);
            end
        end
        wait_rsp(ok);
        repeat (3) @(posedge aclk);
        #1;
        n_cmp++;
        if (!ok || b_count - b0 !== 1 || rsp_write !== 1'b1) begin
            n_err++;
            $display("FAIL skew_b: ok %b b beats %0d write %b expected 1 1 1", ok, b_count - b0, rsp_write);
        end
        take_rsp();
        n_cmp++;
        if (rsp_count - r0 !== 1 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL skew_rsp: responses %0d rsp_valid %b expected 1 0", rsp_count - r0, rsp_valid);
        end
        aw_delay = 0;
    endtask

    task automatic test_backpressure;
        bit ok;
        send(1'b0, 32'hC, 32'h0, 4'h0);
        wait_rsp(ok);
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (!ok || {rsp_valid, rsp_write, rsp_resp, rsp_rdata, cmd_ready, axi.bready, axi.rready} !== {4'b1000, 32'h1357_9BDF, 3'b000}) begin
                n_err++;
                $display("FAIL backpressure c%0d: valid %b write %b resp %b rdata %h crdy %b bready %b rready %b expected 1 0 00 13579bdf 0 0 0",
                         k, rsp_valid, rsp_write, rsp_resp, rsp_rdata, cmd_ready, axi.bready, axi.rready);
            end
            @(posedge aclk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL no_bypass: cmd_ready got %b expected 0", cmd_ready);
        end
        @(posedge aclk); #1;
        rsp_ready = 1'b0;
        n_cmp++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL bp_release: cmd_ready/rsp_valid got %b expected 10", {cmd_ready, rsp_valid});
        end
    endtask

    task automatic test_error;
        bit ok;
        r_err = 1'b1;
        send(1'b0, 32'h10, 32'h0, 4'h0);
        wait_rsp(ok);
        n_cmp++;
        if (!ok || {rsp_resp, rsp_rdata, rsp_write} !== {2'b10, 32'hDEAD_BEEF, 1'b0}) begin
            n_err++;
            $display("FAIL error_pass: ok %b resp %b rdata %h write %b expected 1 10 deadbeef 0", ok, rsp_resp, rsp_rdata, rsp_write);
        end
        take_rsp();
        r_err = 1'b0;
    endtask

    task automatic test_async_reset;
        bit ok;
        b_hold = 1'b1;
        send(1'b1, 32'h20, 32'h1111_2222, 4'hF);
        @(posedge aclk); #1;
        n_cmp++;
        if (axi.bready !== 1'b1) begin
            n_err++;
            $display("FAIL arst_waitb: bready got %b expected 1", axi.bready);
        end
        #2 aresetn = 1'b0;
        #1;
        n_cmp++;
        if ({axi.awvalid, axi.wvalid, axi.arvalid, rsp_valid, axi.bready, cmd_ready} !== 6'b000001) begin
            n_err++;
            $display("FAIL arst_waitb_clear: got %b expected 000001", {axi.awvalid, axi.wvalid, axi.arvalid, rsp_valid, axi.bready, cmd_ready});
        end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        b_hold = 1'b0;
        aw_delay = 10;
        send(1'b1, 32'h20, 32'h3333_4444, 4'hF);
        #2 aresetn = 1'b0;
        #1;
        n_cmp++;
        if ({axi.awvalid, axi.wvalid, cmd_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL arst_write_clear: awv/wv/crdy got %b expected 001", {axi.awvalid, axi.wvalid, cmd_ready});
        end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        aw_delay = 0;
        @(posedge aclk); #1;
        send(1'b1, 32'h20, 32'h0BAD_F00D, 4'hF);
        wait_rsp(ok);
        n_cmp++;
        if (!ok || {rsp_write, rsp_resp} !== 3'b100) begin
            n_err++;
            $display("FAIL arst_after_wr: ok %b write %b resp %b expected 1 1 00", ok, rsp_write, rsp_resp);
        end
        take_rsp();
        send(1'b0, 32'h20, 32'h0, 4'h0);
        wait_rsp(ok);
        n_cmp++;
        if (!ok || rsp_rdata !== 32'h0BAD_F00D) begin
            n_err++;
            $display("FAIL arst_after_rd: ok %b rdata %h expected 0badf00d", ok, rsp_rdata);
        end
        take_rsp();
    endtask

    initial begin
        test_reset();
        test_write_latency();
        test_read();
        test_partial_strobe();
        test_skewed();
        test_backpressure();
        test_error();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
